// File: rtl/decoder_scan_if.sv
// decoder_scan_if: select/control inputs and decoded outputs of decoder_scan.
// With DECODER_SCAN_SKIP_MASK_EN defined, the interface also carries skip_mask.
interface decoder_scan_if #(
    parameter int unsigned SEL_W = 2
) ();
    localparam int unsigned numCh = 2 ** SEL_W;

    logic             en;
    logic             inv;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [numCh-1:0] o;
    logic [SEL_W-1:0] idx;
    logic             wrap;
`ifdef DECODER_SCAN_SKIP_MASK_EN
    logic [numCh-1:0] skip_mask;

    modport master (output en, inv, mode, sel, skip_mask, input o, idx, wrap);
    modport slave  (input en, inv, mode, sel, skip_mask, output o, idx, wrap);
`else
    modport master (output en, inv, mode, sel, input o, idx, wrap);
    modport slave  (input en, inv, mode, sel, output o, idx, wrap);
`endif
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with enable and polarity control.
// It has a direct mode, which decodes sel, and a scan mode, which steps through
// every channel and holds each one for DWELL cycles.
// The optional macro DECODER_SCAN_SKIP_MASK_EN adds skip_mask, which removes
// channels from the scan and blanks the masked lines.
module decoder_scan #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    decoder_scan_if.slave  bus
);
    localparam int unsigned numCh   = 2 ** SEL_W;
    localparam int unsigned dcntW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [dcntW-1:0] dcntLast = dcntW'(DWELL - 1);

    logic [dcntW-1:0] dcnt;
    logic [dcntW-1:0] dcntNextC;
    logic [SEL_W-1:0] idxNextC;
    logic             wrapNextC;
    logic [numCh-1:0] oNextC;

`ifdef DECODER_SCAN_SKIP_MASK_EN
    logic [SEL_W:0]   searchC;

    // Circular search for the first unmasked channel above cur. The search may
    // land on cur itself. The MSB of the result flags that a channel was found.
    function automatic logic [SEL_W:0] findNext(input logic [SEL_W-1:0] cur,
                                                input logic [numCh-1:0] mask);
        logic [SEL_W-1:0] cand;
        logic [SEL_W-1:0] pick;
        logic             found;
        cand  = cur;
        pick  = cur;
        found = 1'b0;
        for (int unsigned k = 0; k < numCh; k++) begin
            cand = cand + SEL_W'(1);
            if (!found && !mask[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return {found, pick};
    endfunction
`endif

    // Next channel, dwell count, wrap pulse and decoded lines.
    always_comb begin
        idxNextC  = bus.idx;
        dcntNextC = dcnt;
        wrapNextC = 1'b0;
`ifdef DECODER_SCAN_SKIP_MASK_EN
        searchC   = findNext(bus.idx, bus.skip_mask);
`endif
        if (bus.en) begin
            if (!bus.mode) begin
                idxNextC  = bus.sel;
                dcntNextC = '0;
            end else if (dcnt == dcntLast) begin
                dcntNextC = '0;
`ifdef DECODER_SCAN_SKIP_MASK_EN
                if (searchC[SEL_W]) begin
                    idxNextC  = searchC[SEL_W-1:0];
                    wrapNextC = (searchC[SEL_W-1:0] <= bus.idx);
                end
`else
                idxNextC  = bus.idx + SEL_W'(1);
                wrapNextC = (idxNextC <= bus.idx);
`endif
            end else begin
                dcntNextC = dcnt + dcntW'(1);
            end
        end

        oNextC = bus.en ? (numCh'(1) << idxNextC) : '0;
`ifdef DECODER_SCAN_SKIP_MASK_EN
        // A masked channel is blanked at once, even before idx moves off it.
        oNextC = oNextC & ~bus.skip_mask;
`endif
        oNextC = oNextC ^ {numCh{bus.inv}};
    end

    // State and output registers. Reset clears o to all zeros regardless of inv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt     <= '0;
            bus.idx  <= '0;
            bus.wrap <= 1'b0;
            bus.o    <= '0;
        end else begin
            dcnt     <= dcntNextC;
            bus.idx  <= idxNextC;
            bus.wrap <= wrapNextC;
            bus.o    <= oNextC;
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed test of decoder_scan. It drives two instances with
// the same inputs, one with DWELL=3 and one with DWELL=1, both with SEL_W=2.
// The skip-mask checks are compiled only when DECODER_SCAN_SKIP_MASK_EN is defined.
module tb_decoder_scan;
    logic clk;
    logic rst_n;
    int   checkCnt;
    int   passCnt;

    decoder_scan_if #(.SEL_W(2)) bus  ();
    decoder_scan_if #(.SEL_W(2)) bus1 ();

    decoder_scan #(.SEL_W(2), .DWELL(3)) uDut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    decoder_scan #(.SEL_W(2), .DWELL(1)) uDut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus1.en   = bus.en;
    assign bus1.inv  = bus.inv;
    assign bus1.mode = bus.mode;
    assign bus1.sel  = bus.sel;
`ifdef DECODER_SCAN_SKIP_MASK_EN
    assign bus1.skip_mask = bus.skip_mask;
`endif

    // Clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ.
    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] expDir [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] expInv [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [1:0] expIdx [19] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3,
                                2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    logic       expWrap [19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] expScanO [19] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                                  4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001,
                                  4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100,
                                  4'b0100};

    initial begin
        checkCnt  = 0;
        passCnt   = 0;
        rst_n     = 1'b0;
        bus.en    = 1'b0;
        bus.inv   = 1'b1;
        bus.mode  = 1'b0;
        bus.sel   = 2'd0;
`ifdef DECODER_SCAN_SKIP_MASK_EN
        bus.skip_mask = 4'b0000;
`endif
        #12;
        checkEq("reset_o",    32'(bus.o),    32'h0);
        checkEq("reset_idx",  32'(bus.idx),  32'h0);
        checkEq("reset_wrap", 32'(bus.wrap), 32'h0);
        checkEq("reset_o1",   32'(bus1.o),   32'h0);

        // Direct decode with active-high lines.
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        bus.inv  = 1'b0;
        bus.en   = 1'b1;
        bus.sel  = 2'd0;
        step();
        checkEq("dir_o0",   32'(bus.o),   32'(expDir[0]));
        checkEq("dir_idx0", 32'(bus.idx), 32'h0);
        for (int s = 1; s < 4; s++) begin
            bus.sel = 2'(s);
            #1;
            checkEq("dir_latency", 32'(bus.o), 32'(expDir[s-1]));
            step();
            checkEq("dir_o",   32'(bus.o),   32'(expDir[s]));
            checkEq("dir_idx", 32'(bus.idx), 32'(s));
        end

        // Direct decode with active-low lines, then disable.
        bus.inv = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.sel = 2'(s);
            step();
            checkEq("inv_o", 32'(bus.o), 32'(expInv[s]));
        end
        bus.en = 1'b0;
        step();
        checkEq("dis_o",    32'(bus.o),    32'hF);
        checkEq("dis_idx",  32'(bus.idx),  32'h3);
        checkEq("dis_wrap", 32'(bus.wrap), 32'h0);

        // Scan from an asynchronous reset: DWELL=3 on uDut and DWELL=1 on uDut1.
        bus.inv  = 1'b0;
        bus.en   = 1'b1;
        bus.mode = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            checkEq("scan_idx",   32'(bus.idx),   32'(expIdx[k-1]));
            checkEq("scan_wrap",  32'(bus.wrap),  32'(expWrap[k-1]));
            checkEq("scan_o",     32'(bus.o),     32'(expScanO[k-1]));
            checkEq("scan1_idx",  32'(bus1.idx),  32'(k % 4));
            checkEq("scan1_wrap", 32'(bus1.wrap), 32'((k % 4) == 0));
        end

        // Gap in the middle of channel 2, which has already been active for two cycles.
        bus.en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checkEq("gap_o",    32'(bus.o),    32'h0);
            checkEq("gap_idx",  32'(bus.idx),  32'h2);
            checkEq("gap_wrap", 32'(bus.wrap), 32'h0);
        end
        bus.en = 1'b1;
        step();
        checkEq("resume_o",   32'(bus.o),   32'b0100);
        checkEq("resume_idx", 32'(bus.idx), 32'h2);
        step();
        checkEq("resume_adv", 32'(bus.o),   32'b1000);
        checkEq("resume_idx3", 32'(bus.idx), 32'h3);
        step();
        checkEq("hold_idx3", 32'(bus.idx), 32'h3);

        // Assert reset asynchronously between clock edges while idx is 3.
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("areset_o",    32'(bus.o),    32'h0);
        checkEq("areset_idx",  32'(bus.idx),  32'h0);
        checkEq("areset_wrap", 32'(bus.wrap), 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        checkEq("restart_o0", 32'(bus.o),   32'b0001);
        step();
        checkEq("restart_idx0", 32'(bus.idx), 32'h0);
        step();
        checkEq("restart_o1", 32'(bus.o),   32'b0010);

        // Switch from scan to direct, then back to scan from the held index.
        bus.mode = 1'b0;
        bus.sel  = 2'd3;
        step();
        checkEq("s2d_idx", 32'(bus.idx), 32'h3);
        checkEq("s2d_o",   32'(bus.o),   32'b1000);
        bus.mode = 1'b1;
        step();
        checkEq("d2s_idx_a", 32'(bus.idx), 32'h3);
        step();
        checkEq("d2s_idx_b", 32'(bus.idx), 32'h3);
        step();
        checkEq("d2s_idx_c", 32'(bus.idx),  32'h0);
        checkEq("d2s_wrap",  32'(bus.wrap), 32'h1);

        // Toggle polarity in the middle of a dwell.
        bus.inv = 1'b1;
        step();
        checkEq("inv_mid_o",   32'(bus.o),    32'b1110);
        checkEq("inv_mid_idx", 32'(bus.idx),  32'h0);
        checkEq("inv_mid_wrap", 32'(bus.wrap), 32'h0);
        bus.inv = 1'b0;
        step();
        checkEq("inv_back_o", 32'(bus.o), 32'b0001);
        step();
        checkEq("inv_adv_o",   32'(bus.o),   32'b0010);
        checkEq("inv_adv_idx", 32'(bus.idx), 32'h1);

`ifdef DECODER_SCAN_SKIP_MASK_EN
        // Skip mask on uDut1 (DWELL=1): only channels 1 and 3 are unmasked.
        bus.skip_mask = 4'b0101;
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        step();
        checkEq("mask_dir_o",   32'(bus1.o),   32'h0);
        checkEq("mask_dir_idx", 32'(bus1.idx), 32'h0);
        bus.sel = 2'd1;
        step();
        checkEq("mask_dir_o1", 32'(bus1.o), 32'b0010);
        bus.mode = 1'b1;
        step();
        checkEq("mask_s1_idx",  32'(bus1.idx),  32'h3);
        checkEq("mask_s1_wrap", 32'(bus1.wrap), 32'h0);
        checkEq("mask_s1_o",    32'(bus1.o),    32'b1000);
        step();
        checkEq("mask_s2_idx",  32'(bus1.idx),  32'h1);
        checkEq("mask_s2_wrap", 32'(bus1.wrap), 32'h1);
        step();
        checkEq("mask_s3_idx",  32'(bus1.idx),  32'h3);
        step();
        checkEq("mask_s4_idx",  32'(bus1.idx),  32'h1);
        checkEq("mask_s4_wrap", 32'(bus1.wrap), 32'h1);
        bus.skip_mask = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            step();
            checkEq("allmask_o",    32'(bus1.o),    32'h0);
            checkEq("allmask_idx",  32'(bus1.idx),  32'h1);
            checkEq("allmask_wrap", 32'(bus1.wrap), 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered one-hot decoder with enable and output polarity control.
- Two modes:
  - direct: a binary select is decoded onto 2^SEL_W lines.
  - scan: an internal counter steps through every line, holding each one for DWELL cycles.
- Intended as the channel/digit-select driver for multiplexed outputs (seven-segment digit strobes, row select) in lab designs.

Parameters:
- SEL_W, 2, select width; output width is 2**SEL_W (legal 1..6).
- DWELL, 4, clock cycles each channel stays active in scan mode (legal >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable; 0 forces all lines inactive and freezes the scan state.
- inv  input  1  polarity; 1 means every output bit is XOR-inverted, giving active-low lines.
- mode  input  1  0 = direct decode, 1 = scan.
- sel  input  SEL_W  channel select, used in direct mode only.
- o  output  2**SEL_W  decoded lines, registered.
- idx  output  SEL_W  index of the currently active channel, registered.
- wrap  output  1  one-cycle pulse when scan returns from the last channel to the first.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: o = 0 (all bits, regardless of inv), idx = 0, wrap = 0, internal dwell counter dcnt = 0.
- Output rule, applied every cycle after reset: o <= (en ? onehot(idx_next) : 0) ^ {2**SEL_W{inv}}. o and idx always describe the same channel in the same cycle.
- Latency: a change on sel, en, inv or mode appears on o exactly 1 cycle later.
- Direct mode (mode=0):
  - idx_next = sel.
  - dcnt <= 0; wrap <= 0.
- Scan mode (mode=1, en=1):
  - If dcnt == DWELL-1: dcnt <= 0 and idx advances to the next channel. Without the optional feature the next channel is idx+1 mod 2**SEL_W.
  - wrap <= 1 on the advance where the new index is numerically lower than or equal to the old one; otherwise wrap <= 0.
  - Else: dcnt <= dcnt+1, idx holds, wrap <= 0.
- DWELL=1: idx advances every cycle. With SEL_W=2, wrap pulses once every 4 cycles.
- en=0 in either mode:
  - o = all inv.
  - idx, dcnt hold.
  - wrap <= 0.
  - When en returns to 1, scanning resumes with the held dcnt.
- Mode switch direct->scan: scan starts from the current idx with dcnt=0, so the first channel dwells the full DWELL cycles.
- Mode switch scan->direct: idx follows sel on the next cycle; dcnt cleared.
- inv toggles mid-scan: only the polarity changes (1-cycle latency); idx/dcnt are unaffected.
- rst_n asserted mid-scan: all state clears immediately (asynchronous). On the first clock after release:
  - scan mode: output decodes channel 0 with dcnt counting from 0.
  - direct mode: output decodes sel.
- dcnt width: clog2(DWELL), minimum 1 bit. It never exceeds DWELL-1.

Optional Feature:
- Macro: DECODER_SCAN_SKIP_MASK_EN.
- Defined:
  - Adds input skip_mask, width 2**SEL_W; bit k=1 removes channel k.
  - Scan: on a dwell expiry, idx moves to the next unmasked channel above idx, searching circularly. wrap follows the same "new <= old" rule.
  - Only one channel unmasked: idx stays on it and wrap pulses every DWELL cycles.
  - Direct: a masked sel gives all-inactive o, but idx still = sel.
  - All channels masked: o all inactive, idx holds, wrap 0.
  - A mask change on the current channel takes effect at the next dwell expiry; output is forced inactive immediately (1 cycle).
- Undefined: no skip_mask port; all channels are scanned.

Test Plan:
- SEL_W=2; rst_n=0 then 1, en=1, inv=0, mode=0, sel=0..3 held 1 cycle each -> o = 0001, 0010, 0100, 1000, each 1 cycle after sel; idx = sel.
- Same sequence with inv=1 -> o = 1110, 1101, 1011, 0111; then en=0 -> o = 1111 next cycle.
- DWELL=3, mode=1, en=1 for 14 cycles -> idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0,0; wrap high exactly on the cycle idx first returns to 0; o one-hot matching idx.
- Scan with en dropped for 5 cycles in the middle of channel 2 -> o all 0 during the gap, idx stays 2; after re-enable, channel 2 finishes its remaining dwell (total 3 active cycles).
- rst_n pulsed low asynchronously (between clock edges) while idx=3 -> o=0, idx=0, wrap=0 immediately; after release, scan restarts at channel 0.
- With DECODER_SCAN_SKIP_MASK_EN, skip_mask=0101, DWELL=1 -> idx 1,3,1,3…, wrap on each 3->1 step; skip_mask=1111 -> o=0000 and idx frozen.
